// File: rtl/d_regfile_2w2r_if.sv
// Bus bundle for the 2-write/2-read register file: read/write ports, status and debug taps.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer watches busy while the clear sweep runs.
interface d_regfile_2w2r_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_TAPS = 4
);
    logic [ADDR_W-1:0]          ra;
    logic [ADDR_W-1:0]          rb;
    logic [DATA_W-1:0]          busa;
    logic [DATA_W-1:0]          busb;
    logic                       we;
    logic [ADDR_W-1:0]          rw;
    logic [DATA_W-1:0]          busw;
    logic                       we2;
    logic [ADDR_W-1:0]          rw2;
    logic [DATA_W-1:0]          busw2;
    logic                       busy;
    logic                       wr_conflict;
    logic [NUM_TAPS*DATA_W-1:0] taps;

    modport master (
        output ra, rb, we, rw, busw, we2, rw2, busw2,
        input  busa, busb, busy, wr_conflict, taps
    );

    modport slave (
        input  ra, rb, we, rw, busw, we2, rw2, busw2,
        output busa, busb, busy, wr_conflict, taps
    );
endinterface

// File: rtl/d_regfile_2w2r.sv
// Register file, two write ports and two combinational read ports, with a post-reset clear sweep.
// Latency: reads 0 cycles (same-cycle write forwarding); writes land on the next edge.
// Backpressure: none; writes are dropped while busy is high during the DEPTH-cycle sweep.
module d_regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_TAPS = 4,
    parameter int TAP_BASE = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    d_regfile_2w2r_if.slave   rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_wr_conflict;
    logic              w_conflict_nxt;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_run;
    logic              w_we1_eff;
    logic              w_we2_eff;
    logic [DATA_W-1:0] w_busa;
    logic [DATA_W-1:0] w_busb;

    // Writes into register 0 are squashed here so they neither store, forward nor conflict.
    assign w_run     = (r_state == ST_RUN) && !rst;
    assign w_we1_eff = w_run && rf.we  && !(ZR && (rf.rw  == '0));
    assign w_we2_eff = w_run && rf.we2 && !(ZR && (rf.rw2 == '0));

    always_ff @(posedge clk) begin
        r_state       <= w_state_nxt;
        r_clr_ptr     <= w_clr_ptr_nxt;
        r_busy        <= w_busy_nxt;
        r_wr_conflict <= w_conflict_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_ptr_nxt  = r_clr_ptr;
        w_busy_nxt     = r_busy;
        w_conflict_nxt = 1'b0;
        if (rst) begin
            w_state_nxt   = ST_CLEAR;
            w_clr_ptr_nxt = '0;
            w_busy_nxt    = 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == LAST_ADDR) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                    end
                end
                ST_RUN: begin
                    w_conflict_nxt = w_we1_eff && w_we2_eff && (rf.rw == rf.rw2);
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                end
            endcase
        end
    end

    // Port 2 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_clr_ptr] <= '0;
            end else begin
                if (w_we1_eff) begin
                    r_regs[rf.rw] <= rf.busw;
                end
                if (w_we2_eff) begin
                    r_regs[rf.rw2] <= rf.busw2;
                end
            end
        end
    end

    always_comb begin
        w_busa = '0;
        if (r_state == ST_RUN && !(ZR && (rf.ra == '0))) begin
            if (w_we2_eff && (rf.rw2 == rf.ra)) begin
                w_busa = rf.busw2;
            end else if (w_we1_eff && (rf.rw == rf.ra)) begin
                w_busa = rf.busw;
            end else begin
                w_busa = r_regs[rf.ra];
            end
        end
    end

    always_comb begin
        w_busb = '0;
        if (r_state == ST_RUN && !(ZR && (rf.rb == '0))) begin
            if (w_we2_eff && (rf.rw2 == rf.rb)) begin
                w_busb = rf.busw2;
            end else if (w_we1_eff && (rf.rw == rf.rb)) begin
                w_busb = rf.busw;
            end else begin
                w_busb = r_regs[rf.rb];
            end
        end
    end

    assign rf.busa        = w_busa;
    assign rf.busb        = w_busb;
    assign rf.busy        = r_busy;
    assign rf.wr_conflict = r_wr_conflict;

    // Taps expose raw storage; the sweep leaves contents undefined until it finishes.
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'((TAP_BASE + gi) % DEPTH);
        assign rf.taps[gi*DATA_W +: DATA_W] = (r_state == ST_RUN) ? r_regs[TAP_IDX] : '0;
    end
endmodule

// File: tb/tb_d_regfile_2w2r.sv
// Self-checking bench: default and small-parameter register files against a behavioural model.
module tb_d_regfile_2w2r;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_rst;
    logic [4:0]  t_ra, t_rb, t_rw, t_rw2;
    logic [31:0] t_busw, t_busw2;
    logic        t_we, t_we2;

    d_regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5), .NUM_TAPS(4)) i0 ();
    d_regfile_2w2r_if #(.DATA_W(16), .ADDR_W(3), .NUM_TAPS(3)) i1 ();

    assign i0.ra = t_ra;       assign i1.ra = t_ra[2:0];
    assign i0.rb = t_rb;       assign i1.rb = t_rb[2:0];
    assign i0.rw = t_rw;       assign i1.rw = t_rw[2:0];
    assign i0.rw2 = t_rw2;     assign i1.rw2 = t_rw2[2:0];
    assign i0.busw = t_busw;   assign i1.busw = t_busw[15:0];
    assign i0.busw2 = t_busw2; assign i1.busw2 = t_busw2[15:0];
    assign i0.we = t_we;       assign i1.we = t_we;
    assign i0.we2 = t_we2;     assign i1.we2 = t_we2;

    d_regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .NUM_TAPS(4), .TAP_BASE(4), .ZERO_REG(1))
        u_dut0 (.clk(clk), .rst(t_rst), .rf(i0));
    d_regfile_2w2r #(.DATA_W(16), .ADDR_W(3), .NUM_TAPS(3), .TAP_BASE(6), .ZERO_REG(0))
        u_dut1 (.clk(clk), .rst(t_rst), .rf(i1));

    // Reference model: sweep countdown, register array, conflict flag.
    bit          sel;
    int          m_depth, m_ntaps, m_base;
    bit          m_zr;
    logic [31:0] m_mask;
    int          m_left;
    bit          m_conf;
    logic [31:0] m_regs [32];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_busa();
        return sel ? 32'(i1.busa) : i0.busa;
    endfunction
    function automatic logic [31:0] obs_busb();
        return sel ? 32'(i1.busb) : i0.busb;
    endfunction
    function automatic logic obs_busy();
        return sel ? i1.busy : i0.busy;
    endfunction
    function automatic logic obs_conf();
        return sel ? i1.wr_conflict : i0.wr_conflict;
    endfunction
    function automatic logic [31:0] obs_tap(input int i);
        return sel ? 32'(i1.taps[i*16 +: 16]) : i0.taps[i*32 +: 32];
    endfunction

    function automatic int a_of(input logic [4:0] a);
        return int'(a) % m_depth;
    endfunction
    function automatic bit eff1();
        return (m_left == 0) && !t_rst && t_we && !(m_zr && a_of(t_rw) == 0);
    endfunction
    function automatic bit eff2();
        return (m_left == 0) && !t_rst && t_we2 && !(m_zr && a_of(t_rw2) == 0);
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (m_left > 0) return 32'h0;
        if (m_zr && a == 0) return 32'h0;
        if (eff2() && a_of(t_rw2) == a) return t_busw2 & m_mask;
        if (eff1() && a_of(t_rw) == a) return t_busw & m_mask;
        return m_regs[a];
    endfunction

    task automatic check_outputs();
        chk("busy", 32'(obs_busy()), 32'(m_left > 0));
        chk("wr_conflict", 32'(obs_conf()), 32'(m_conf));
        chk("busa", obs_busa(), exp_read(a_of(t_ra)));
        chk("busb", obs_busb(), exp_read(a_of(t_rb)));
        for (int i = 0; i < m_ntaps; i++)
            chk("tap", obs_tap(i), (m_left > 0) ? 32'h0 : m_regs[(m_base + i) % m_depth]);
    endtask

    task automatic model_edge();
        bit e1, e2;
        e1 = eff1();
        e2 = eff2();
        if (t_rst) begin
            m_left = m_depth;
            m_conf = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_conf = 1'b0;
            if (m_left == 0)
                for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            if (e1) m_regs[a_of(t_rw)] = t_busw & m_mask;
            if (e2) m_regs[a_of(t_rw2)] = t_busw2 & m_mask;
            m_conf = e1 && e2 && (a_of(t_rw) == a_of(t_rw2));
        end
    endtask

    task automatic settle();
        #1;
        if (!t_rst) check_outputs();
    endtask
    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic cycle();
        settle();
        edge_step();
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
    endfunction

    task automatic rand_inputs();
        t_we    = 1'($urandom_range(0, 1));
        t_we2   = 1'($urandom_range(0, 1));
        t_rw    = rand_addr();
        t_rw2   = ($urandom_range(0, 3) == 0) ? t_rw : rand_addr();
        t_ra    = ($urandom_range(0, 2) == 0) ? t_rw2 : rand_addr();
        t_rb    = ($urandom_range(0, 2) == 0) ? t_rw : rand_addr();
        t_busw  = $urandom;
        t_busw2 = $urandom;
    endtask

    task automatic sweep_len(input string tag);
        int n = 0;
        while (obs_busy() && n < 100) begin
            rand_inputs();
            t_we = 1'b1;
            cycle();
            n++;
        end
        chk(tag, 32'(n), 32'(m_depth));
    endtask

    task automatic do_reset();
        t_rst = 1'b1;
        cycle();
        t_rst = 1'b0;
    endtask

    initial begin
        t_rst = 1'b1; t_we = 1'b0; t_we2 = 1'b0;
        t_ra = '0; t_rb = '0; t_rw = '0; t_rw2 = '0; t_busw = '0; t_busw2 = '0;

        // Default configuration
        sel = 1'b0; m_depth = 32; m_ntaps = 4; m_base = 4; m_zr = 1'b1; m_mask = 32'hFFFF_FFFF;
        m_left = 0; m_conf = 1'b0;
        do_reset();
        chk("reset_busy", 32'(obs_busy()), 32'h1);
        chk("reset_conflict", 32'(obs_conf()), 32'h0);
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            t_we = 1'b1;
            cycle();
        end
        do_reset();
        sweep_len("busy_len_after_midsweep_reset");

        t_we = 1'b0; t_we2 = 1'b0;
        for (int a = 0; a < 32; a++) begin
            t_ra = 5'(a);
            t_rb = 5'(31 - a);
            settle();
            chk("cleared", obs_busa(), 32'h0);
            edge_step();
        end

        t_we = 1'b1; t_rw = 5'd5; t_busw = 32'hDEADBEEF; t_ra = 5'd5; t_we2 = 1'b0;
        settle();
        chk("fwd_a", obs_busa(), 32'hDEADBEEF);
        edge_step();
        t_we = 1'b0;
        settle();
        chk("stored_a", obs_busa(), 32'hDEADBEEF);
        chk("tap1", obs_tap(1), 32'hDEADBEEF);
        edge_step();

        t_we = 1'b1; t_we2 = 1'b1; t_rw = 5'd7; t_rw2 = 5'd7;
        t_busw = 32'h11; t_busw2 = 32'h22; t_ra = 5'd7;
        settle();
        chk("fwd_port2_wins", obs_busa(), 32'h22);
        edge_step();
        t_we = 1'b0; t_we2 = 1'b0;
        settle();
        chk("conflict_pulse", 32'(obs_conf()), 32'h1);
        chk("conflict_data", obs_busa(), 32'h22);
        edge_step();
        settle();
        chk("conflict_one_cycle", 32'(obs_conf()), 32'h0);
        edge_step();

        t_we = 1'b1; t_we2 = 1'b1; t_rw = 5'd0; t_rw2 = 5'd0;
        t_busw = 32'h1234; t_busw2 = 32'h5678; t_ra = 5'd0;
        settle();
        chk("zero_no_fwd", obs_busa(), 32'h0);
        edge_step();
        t_we = 1'b0; t_we2 = 1'b0;
        settle();
        chk("zero_no_conflict", 32'(obs_conf()), 32'h0);
        chk("zero_reg", obs_busa(), 32'h0);
        edge_step();

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Small configuration: 8 registers, 16-bit, taps 6,7,0, register 0 writable
        sel = 1'b1; m_depth = 8; m_ntaps = 3; m_base = 6; m_zr = 1'b0; m_mask = 32'h0000_FFFF;
        do_reset();
        sweep_len("busy_len_small");

        t_we = 1'b1; t_rw = 5'd6; t_busw = 32'h0000_A1A1;
        t_we2 = 1'b1; t_rw2 = 5'd7; t_busw2 = 32'h0000_B2B2;
        cycle();
        t_we = 1'b1; t_rw = 5'd0; t_busw = 32'h0000_C3C3; t_we2 = 1'b0; t_ra = 5'd0;
        settle();
        chk("r0_fwd_small", obs_busa(), 32'h0000_C3C3);
        edge_step();
        t_we = 1'b0;
        settle();
        chk("tap_reg6", obs_tap(0), 32'h0000_A1A1);
        chk("tap_reg7", obs_tap(1), 32'h0000_B2B2);
        chk("tap_reg0", obs_tap(2), 32'h0000_C3C3);
        chk("r0_writable", obs_busa(), 32'h0000_C3C3);
        edge_step();

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
